cnoc_indication_serializer: RTL

//  Downstream of the CNOC top: drains 128-bit indication messages from its

---
 rtl/cnoc_indication_serializer_if.sv | 30 +++
 rtl/cnoc_indication_serializer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/cnoc_indication_serializer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cnoc_indication_serializer_if                              |
// | Description : Message-in / word-out bus bundle for the indication         |
// |               serializer. master = serializer side, slave = peer side.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface cnoc_indication_serializer_if #(
  parameter int MSG_WIDTH  = 128,
  parameter int WORD_WIDTH = 32
) ();
  logic                  in_rdy;
  logic [MSG_WIDTH-1:0]  in_first;
  logic                  in_deq;
  logic [WORD_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    input  in_rdy, in_first, out_ready,
    output in_deq, out_data, out_valid, out_last
  );

  modport slave (
    output in_rdy, in_first, out_ready,
    input  in_deq, out_data, out_valid, out_last
  );
endinterface
`default_nettype wire

// File: rtl/cnoc_indication_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cnoc_indication_serializer                                 |
// | Description : Drains 128-bit indication messages and emits them as a      |
// |               32-bit valid/ready/last word stream. Header word carries    |
// |               numWords (clamped to 1..4 internally) and indicationId.     |
// |               Keeps a wrapping message counter and a sticky len error.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module cnoc_indication_serializer #(
  parameter int MSG_WIDTH  = 128,
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  wire                         CLK,
  input  wire                         RST,
  cnoc_indication_serializer_if.master bus,
  output logic [CNT_WIDTH-1:0]        msg_count,
  output logic                        len_err,
  input  wire                         len_err_clr
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                r_state,     w_state_nxt;
  logic [MSG_WIDTH-1:0]  r_buf,       w_buf_nxt;
  logic [2:0]            r_len,       w_len_nxt;
  logic [1:0]            r_idx,       w_idx_nxt;
  logic [WORD_WIDTH-1:0] r_out_data,  w_out_data_nxt;
  logic                  r_out_valid, w_out_valid_nxt;
  logic                  r_out_last,  w_out_last_nxt;
  logic [CNT_WIDTH-1:0]  r_msg_count, w_msg_count_nxt;
  logic                  r_len_err,   w_len_err_nxt;

  logic                  w_deq;
  logic                  w_accept;
  logic [1:0]            w_idx_inc;
  logic [15:0]           w_hdr_nw;
  logic [2:0]            w_hdr_len;
  logic                  w_hdr_err;

  assign w_hdr_nw  = bus.in_first[15:0];
  assign w_accept  = r_out_valid && bus.out_ready;
  assign w_idx_inc = r_idx + 2'd1;

  // Clamp the header word count into the 1..4 range and flag out-of-range values.
  always_comb begin
    w_hdr_len = w_hdr_nw[2:0];
    w_hdr_err = 1'b0;
    if (w_hdr_nw == 16'd0) begin
      w_hdr_len = 3'd1;
      w_hdr_err = 1'b1;
    end else if (w_hdr_nw > 16'd4) begin
      w_hdr_len = 3'd4;
      w_hdr_err = 1'b1;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead so
  // that the word stream comes straight from flops.
  always_comb begin
    w_state_nxt     = r_state;
    w_buf_nxt       = r_buf;
    w_len_nxt       = r_len;
    w_idx_nxt       = r_idx;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_out_last_nxt  = r_out_last;
    w_msg_count_nxt = r_msg_count;
    w_deq           = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_out_valid_nxt = 1'b0;
        w_out_last_nxt  = 1'b0;
        if (bus.in_rdy) begin
          // Capture cycle: the header word is presented on the very next cycle.
          w_deq           = 1'b1;
          w_buf_nxt       = bus.in_first;
          w_len_nxt       = w_hdr_len;
          w_idx_nxt       = 2'd0;
          w_out_data_nxt  = bus.in_first[WORD_WIDTH-1:0];
          w_out_valid_nxt = 1'b1;
          w_out_last_nxt  = (w_hdr_len == 3'd1);
          w_state_nxt     = S_SEND;
        end
      end
      S_SEND: begin
        if (w_accept) begin
          if (r_out_last) begin
            w_state_nxt     = S_IDLE;
            w_out_valid_nxt = 1'b0;
            w_out_last_nxt  = 1'b0;
            w_msg_count_nxt = r_msg_count + CNT_WIDTH'(1);
          end else begin
            w_idx_nxt      = w_idx_inc;
            w_out_data_nxt = r_buf[int'(w_idx_inc)*WORD_WIDTH +: WORD_WIDTH];
            w_out_last_nxt = ({1'b0, w_idx_inc} == (r_len - 3'd1));
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // A new error in the same cycle as a clear keeps the flag set.
    w_len_err_nxt = (r_len_err && !len_err_clr) || (w_deq && w_hdr_err);
  end

  // State and datapath registers with synchronous reset; a partial message is dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_buf       <= '0;
      r_len       <= 3'd1;
      r_idx       <= 2'd0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_msg_count <= '0;
      r_len_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_buf       <= w_buf_nxt;
      r_len       <= w_len_nxt;
      r_idx       <= w_idx_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
      r_msg_count <= w_msg_count_nxt;
      r_len_err   <= w_len_err_nxt;
    end
  end

  // The dequeue strobe is the only combinational output; it is held off during reset.
  assign bus.in_deq    = w_deq && !RST;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign msg_count     = r_msg_count;
  assign len_err       = r_len_err;

endmodule
`default_nettype wire
